// File: rtl/serial_comparator_system.sv
// serial_comparator_system: MSB-first serial magnitude comparator, f=1 while X>Y over the bits seen so far
module serial_comparator_system (
   input  logic clk,
   input  logic rst,
   input  logic A,
   input  logic B,
   input  logic x,
   input  logic y,
   output logic f
);
   typedef enum logic [1:0] {EQ = 2'b00, GT = 2'b01, LT = 2'b10} state_t;
   state_t s, base, nxt;
   // The unused encoding falls back to EQ, like a word start
   always_comb begin
      base = (A || !(s == GT || s == LT)) ? EQ : s;
      nxt = (B && base == EQ && x != y) ? (x ? GT : LT) : base;
   end
   always_ff @(posedge clk) begin
      if (rst) s <= EQ;
      else s <= nxt;
   end
   assign f = (s == GT);
endmodule

// File: tb/tb_serial_comparator_system.sv
// tb_serial_comparator_system: directed vector table, single-bit sweep and random words checked against a numeric model
module tb_serial_comparator_system;
   logic clk = 0, rst = 0, A = 0, B = 0, x = 0, y = 0;
   logic f;
   int checks = 0, errors = 0;
   typedef struct packed {logic r, a, b, xi, yi, fe;} vec_t;
   vec_t tbl[$];
   longint unsigned xv, yv;
   int len;

   serial_comparator_system dut (.clk(clk), .rst(rst), .A(A), .B(B), .x(x), .y(y), .f(f));

   always #10 clk = ~clk;

   task automatic step(input logic r, a, b, xi, yi, input logic fe, input string nm);
      rst = r; A = a; B = b; x = xi; y = yi;
      @(posedge clk);
      #1;
      checks++;
      if (f !== fe) begin
         errors++;
         $display("FAIL %s: f=%b expected %b (rst=%b A=%b B=%b x=%b y=%b)", nm, f, fe, r, a, b, xi, yi);
      end
   endtask

   initial begin
      // fields: rst A B x y expected_f
      tbl = '{
         6'b111110, 6'b111110, 6'b000000,
         6'b011110, 6'b001000, 6'b001101, 6'b001111,
         6'b011010, 6'b001100, 6'b001100, 6'b001000,
         6'b011101,
         6'b000001, 6'b000001, 6'b000001, 6'b001011,
         6'b011101,
         6'b011000, 6'b001101,
         6'b010000, 6'b001101,
         6'b100000, 6'b001101
      };
      for (int i = 0; i < tbl.size(); i++)
         step(tbl[i].r, tbl[i].a, tbl[i].b, tbl[i].xi, tbl[i].yi, tbl[i].fe, $sformatf("table[%0d]", i));
      for (int i = 0; i < 16; i++) begin
         logic [3:0] v;
         v = 4'(i);
         step(1, 0, 0, 0, 0, 0, "sweep_reset");
         step(0, v[3], v[2], v[1], v[0], v[2] & v[1] & ~v[0], $sformatf("sweep[%0d]", i));
      end
      // random words: X and Y accumulated as integers, f is simply X > Y
      step(1, 0, 0, 0, 0, 0, "rand_reset");
      xv = 0; yv = 0; len = 0;
      for (int i = 0; i < 3000; i++) begin
         logic r, a, b, xi, yi;
         r = ($urandom_range(31) == 0);
         a = ($urandom_range(7) == 0) || len >= 60;
         b = ($urandom_range(3) != 0);
         xi = 1'($urandom);
         yi = ($urandom_range(2) == 0) ? 1'($urandom) : xi;
         if (r || a) begin xv = 0; yv = 0; len = 0; end
         if (!r && b) begin
            xv = (xv << 1) | longint'(xi);
            yv = (yv << 1) | longint'(yi);
            len++;
         end
         step(r, a, b, xi, yi, xv > yv, $sformatf("random[%0d]", i));
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
